// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, executor FSM states and op classification helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_XOR   = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_ADD2  = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_PASSB = 4'b1010,
        OP_SLT   = 4'b1100,
        OP_SLL   = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational single-cycle ALU operations; shift and unknown codes yield zero.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:          result = a & b;
            OP_XOR:          result = a ^ b;
            OP_OR:           result = a | b;
            OP_ADD, OP_ADD2: result = a + b;
            OP_SUB:          result = a - b;
            OP_EQ:           result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_PASSB:        result = b;
            OP_SLT:          result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// ALU executor: single-cycle ops via alu_comb_core, shifts iterated one bit per cycle,
// result returned over a valid/ready handshake.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [3:0]       sop;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_res;
    logic [WIDTH-1:0] accept_res;
    logic [WIDTH-1:0] shift_next;

    assign shamt = b[SHW-1:0];

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (comb_res)
    );

    // A shift accepted in IDLE only completes immediately when shamt is zero, so it returns a.
    always_comb begin
        accept_res = comb_res;
        if (is_shift(op)) begin
            accept_res = a;
        end
    end

    always_comb begin
        shift_next = work;
        case (sop)
            OP_SRL:  shift_next = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
            default: shift_next = work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            work      <= '0;
            cnt       <= '0;
            sop       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_shift(op) && (shamt != '0)) begin
                            work  <= a;
                            cnt   <= shamt;
                            sop   <= op;
                            state <= ST_SHIFT;
                        end else begin
                            result    <= accept_res;
                            zero      <= (accept_res == '0);
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= shift_next;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
